// File: rtl/addsub_op_sequencer_pkg.sv
// Shared constants for the add/sub operand sequencer: state encoding, button
// indices, operation codes and the signed-overflow helper.
package addsub_op_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_B  = 3'd1,
        EXEC    = 3'd2,
        CAPTURE = 3'd3,
        SHOW    = 3'd4
    } state_t;

    localparam int BTN_CLR = 0;
    localparam int BTN_ADD = 1;
    localparam int BTN_SUB = 2;
    localparam int BTN_ENT = 3;

    localparam logic ADD = 1'b1;
    localparam logic SUB = 1'b0;

    // Overflow depends only on the sign bits of a, b and the sum.
    function automatic logic signed_ovf(input logic add, input logic a_msb,
                                        input logic b_msb, input logic s_msb);
        if (add)
            return (a_msb == b_msb) && (s_msb != a_msb);
        else
            return (a_msb != b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/addsub_op_sequencer_btn_edge_tick.sv
// Four-button rising-edge detector that only samples on prescaler ticks, so a
// held level yields exactly one edge however long it stays high.
module btn_edge_tick (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] btn,
    output logic [3:0] rise
);

    logic [3:0] btn_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            btn_prev <= 4'b0000;
        else if (tick)
            btn_prev <= btn;
    end

    assign rise = tick ? (btn & ~btn_prev) : 4'b0000;

endmodule

// File: rtl/addsub_op_sequencer.sv
// Operand-entry/execution controller for a shared signed adder/subtractor.
// Build option: define ADDSUB_ACCUM_EN to chain results back into operand A.
module addsub_op_sequencer
    import addsub_op_sequencer_pkg::*;
#(
    parameter int W       = 8,
    parameter int TIMEOUT = 0,
    parameter int TW      = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic [3:0]   btn,
    input  logic [W-1:0] sw,
    input  logic [W-1:0] sum,
    output logic [W-1:0] op_a,
    output logic [W-1:0] op_b,
    output logic         add_sub,
    output logic [W-1:0] result,
    output logic         ovf,
    output logic         select,
    output logic         busy,
    output logic [2:0]   state_dbg
);

    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    logic [3:0]    rise;
    state_t        state, next_state;
    logic [W-1:0]  next_op_a, next_op_b, next_result;
    logic          next_add_sub, next_ovf, next_select, ovf_now;
    logic [TW-1:0] tmo_cnt, next_tmo_cnt;

    btn_edge_tick u_edge (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .btn   (btn),
        .rise  (rise)
    );

    assign ovf_now = signed_ovf(add_sub, op_a[W-1], op_b[W-1], sum[W-1]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_a    <= '0;
            op_b    <= '0;
            add_sub <= ADD;
            result  <= '0;
            ovf     <= 1'b0;
            select  <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            op_a    <= next_op_a;
            op_b    <= next_op_b;
            add_sub <= next_add_sub;
            result  <= next_result;
            ovf     <= next_ovf;
            select  <= next_select;
            tmo_cnt <= next_tmo_cnt;
        end
    end

    always_comb begin
        next_state   = state;
        next_op_a    = op_a;
        next_op_b    = op_b;
        next_add_sub = add_sub;
        next_result  = result;
        next_ovf     = ovf;
        next_select  = select;
        next_tmo_cnt = tmo_cnt;

        // rise is already tick-qualified, but EXEC/CAPTURE/recovery must also wait for a tick.
        if (tick) begin
            if (rise[BTN_CLR]) begin
                next_state  = IDLE;
                next_select = 1'b0;
                next_ovf    = 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise[BTN_ADD]) begin
                            next_op_a    = sw;
                            next_add_sub = ADD;
                            next_state   = WAIT_B;
                        end else if (rise[BTN_SUB]) begin
                            next_op_a    = sw;
                            next_add_sub = SUB;
                            next_state   = WAIT_B;
                        end
                    end
                    WAIT_B: begin
                        if (rise[BTN_ENT]) begin
                            next_op_b  = sw;
                            next_state = EXEC;
                        end
                    end
                    EXEC: next_state = CAPTURE;
                    CAPTURE: begin
                        next_result  = sum;
`ifdef ADDSUB_ACCUM_EN
                        next_ovf     = ovf | ovf_now;
`else
                        next_ovf     = ovf_now;
`endif
                        next_select  = 1'b1;
                        next_tmo_cnt = '0;
                        next_state   = SHOW;
                    end
                    SHOW: begin
`ifdef ADDSUB_ACCUM_EN
                        if (rise[BTN_ADD] || rise[BTN_SUB]) begin
                            next_op_a    = result;
                            next_add_sub = rise[BTN_ADD] ? ADD : SUB;
                            next_select  = 1'b0;
                            next_state   = WAIT_B;
                        end else
`endif
                        if (TIMEOUT > 0) begin
                            if (tmo_cnt == TMO_LAST) begin
                                next_select = 1'b0;
                                next_state  = IDLE;
                            end else begin
                                next_tmo_cnt = tmo_cnt + 1'b1;
                            end
                        end
                    end
                    default: next_state = IDLE;
                endcase
            end
        end
    end

    assign busy      = (state == EXEC) || (state == CAPTURE);
    assign state_dbg = state;

endmodule
